uart_tx: RTL and testbench

- Serial UART transmitter: the stage directly downstream of baud_generator.
- Consumes the one-cycle baud_tick pulse and a byte-wide valid/ready stream, and drives an asynchronous serial line (start, data LSB-first, optional parity, stop).
- A one-entry holding register allows back-to-back frames with no idle gap.
- Instantiated in tt_um_javibajocero_top; tx is driven to a uo_out bit.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared encodings, tx state type and parity helper (Rev 1.0)   |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } tx_state_e;

  // XOR of the low nbits of data; inverted for odd parity.
  function automatic logic parity_bit(input logic [8:0]  data,
                                      input int unsigned nbits,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx : baud-tick driven UART transmitter with one-entry holding reg   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e              state_q, state_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]   hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, busy_q;
  logic                   load;

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_d       = par_q;
    tx_d        = tx_q;
    load        = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
    end

    if (baud_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) load = 1'b1;
        end
        ST_START: begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = 4'd0;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            // A waiting byte starts on this very tick, so frames abut.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end

    // load needs a full holding register and accept needs an empty one,
    // so the two never collide.
    if (load) begin
      state_d     = ST_START;
      tx_d        = 1'b0;
      shift_d     = hold_data_q;
      par_d       = parity_bit(9'(hold_data_q), DATA_BITS, PARITY);
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= 4'd0;
      stop_cnt_q  <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      ready_q     <= ~hold_full_d;
      busy_q      <= (state_d != ST_IDLE) | hold_full_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx : directed scoreboard bench for four uart_tx configurations   |
// +--------------------------------------------------------------------------+
module tb_uart_tx;

  localparam int PMODE [4] = '{0, 2, 1, 0};
  localparam int STOPS [4] = '{1, 1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic [3:0] tx_valid;
  logic [7:0] tx_data [4];
  logic [3:0] tx_ready;
  logic [3:0] tx;
  logic [3:0] busy;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic exp_q [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .DATA_BITS (8),
      .PARITY    (PMODE[g]),
      .STOP_BITS (STOPS[g])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick),
      .tx_data   (tx_data[g]),
      .tx_valid  (tx_valid[g]),
      .tx_ready  (tx_ready[g]),
      .tx        (tx[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk baud_tick every 4 clk, changed on the falling edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!baud_tick && n < 8);
    if (!baud_tick) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s tick_timeout observed=0 expected=1", tag);
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (PMODE[k] == 2) exp_q.push_back(($countones(d) % 2) == 1);
    if (PMODE[k] == 1) exp_q.push_back(($countones(d) % 2) == 0);
    for (int s = 0; s < STOPS[k]; s++) exp_q.push_back(1'b1);
  endtask

  // Accept lands one clk before a tick, so the frame starts on that tick.
  task automatic send_aligned(input int k, input logic [7:0] d, input string tag);
    wait_tick(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tx_data[k]  = d;
    tx_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " ready_after_accept"}, {7'd0, tx_ready[k]}, 8'd0);
    chk({tag, " busy_after_accept"}, {7'd0, busy[k]}, 8'd1);
    chk({tag, " tx_before_start"}, {7'd0, tx[k]}, 8'd1);
    @(negedge clk);
    tx_valid[k] = 1'b0;
  endtask

  task automatic check_frame(input int k, input string tag, input bit first_ready);
    logic b;
    bit   first;
    first = first_ready;
    while (exp_q.size() > 0) begin
      wait_tick(tag);
      #1;
      b = exp_q.pop_front();
      chk({tag, " bit"}, {7'd0, tx[k]}, {7'd0, b});
      chk({tag, " busy"}, {7'd0, busy[k]}, 8'd1);
      if (first) chk({tag, " ready_1clk"}, {7'd0, tx_ready[k]}, 8'd1);
      first = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " bit_hold"}, {7'd0, tx[k]}, {7'd0, b});
    end
    wait_tick(tag);
    #1;
    chk({tag, " busy_end"}, {7'd0, busy[k]}, 8'd0);
    chk({tag, " tx_idle"}, {7'd0, tx[k]}, 8'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 4'b0;
    for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_tx%0d", i), {7'd0, tx[i]}, 8'd1);
      chk($sformatf("reset_ready%0d", i), {7'd0, tx_ready[i]}, 8'd1);
      chk($sformatf("reset_busy%0d", i), {7'd0, busy[i]}, 8'd0);
    end

    // Plain 8N1 frame.
    push_frame(0, 8'h55);
    send_aligned(0, 8'h55, "f55");
    check_frame(0, "f55", 1'b1);

    // Even then odd parity on the same byte.
    push_frame(1, 8'hA3);
    send_aligned(1, 8'hA3, "evenA3");
    check_frame(1, "evenA3", 1'b1);
    push_frame(2, 8'hA3);
    send_aligned(2, 8'hA3, "oddA3");
    check_frame(2, "oddA3", 1'b1);

    // Two stop bits.
    push_frame(3, 8'hFF);
    send_aligned(3, 8'hFF, "stop2FF");
    check_frame(3, "stop2FF", 1'b1);

    // Back-to-back with tx_valid held high.
    push_frame(0, 8'h01);
    push_frame(0, 8'h80);
    wait_tick("b2b");
    fork
      begin
        int n;
        @(negedge clk);
        tx_data[0]  = 8'h01;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data[0] = 8'h80;
        n = 0;
        while (!tx_ready[0] && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("b2b ready_for_second", {7'd0, tx_ready[0]}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
      end
      check_frame(0, "b2b", 1'b0);
    join

    // Accept coincident with a tick: that tick is not used.
    wait_tick("same");
    repeat (3) @(posedge clk);
    @(negedge clk);
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("same tick_at_accept", {7'd0, baud_tick}, 8'd1);
    chk("same tx_high", {7'd0, tx[0]}, 8'd1);
    chk("same ready_low", {7'd0, tx_ready[0]}, 8'd0);
    chk("same busy_high", {7'd0, busy[0]}, 8'd1);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("same tx_still_high", {7'd0, tx[0]}, 8'd1);
    push_frame(0, 8'h3C);
    check_frame(0, "same", 1'b0);

    // Reset during data bit 3 with a second byte waiting.
    wait_tick("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    tx_data[0]  = 8'hF0;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data[0] = 8'h12;
    @(negedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) wait_tick("rst");
    #1;
    chk("rst bit3_low", {7'd0, tx[0]}, 8'd0);
    chk("rst hold_full", {7'd0, tx_ready[0]}, 8'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst async_tx", {7'd0, tx[0]}, 8'd1);
    chk("rst async_ready", {7'd0, tx_ready[0]}, 8'd1);
    chk("rst async_busy", {7'd0, busy[0]}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick("post_rst");
      #1;
      chk("post_rst tx", {7'd0, tx[0]}, 8'd1);
      chk("post_rst busy", {7'd0, busy[0]}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
